// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU): 32 CALC cycles, then a one-cycle DONE with ready pulse.
// Optional macro DIV_ZERO_FAST_EN adds a ZERO state that resolves a zero divisor in two cycles.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_opr1,
  input  logic [31:0] div_opr2,
  input  logic        div_cancel,
  output logic        div_busy,
  output logic        div_ready,
  output logic [31:0] div_quo,
  output logic [31:0] div_rem,
  output logic [1:0]  div_dbg_state
);

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2, S_ZERO = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic        r_qsign;
  logic        r_rsign;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_partial;
  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;

  // 0x80000000 negates to itself and is then read as unsigned 2^31.
  assign w_a_mag = (div_signed & div_opr1[31]) ? (32'd0 - div_opr1) : div_opr1;
  assign w_b_mag = (div_signed & div_opr2[31]) ? (32'd0 - div_opr2) : div_opr2;

  // rem < |b| keeps the trial result below 2^32, so bit 32 is a clean borrow flag.
  assign w_partial  = {r_rem, r_dvd[31]};
  assign w_trial    = w_partial - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[32];
  assign w_rem_next = w_qbit ? w_trial[31:0] : w_partial[31:0];
  assign w_quo_next = {r_quo[30:0], w_qbit};

  assign div_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_dvd     <= 32'd0;
      r_dvs     <= 32'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_qsign   <= 1'b0;
      r_rsign   <= 1'b0;
      div_busy  <= 1'b0;
      div_ready <= 1'b0;
      div_quo   <= 32'd0;
      div_rem   <= 32'd0;
    end else if (div_cancel) begin
      r_state   <= S_IDLE;
      div_busy  <= 1'b0;
      div_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          div_ready <= 1'b0;
          if (div_start) begin
            r_dvd    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_cnt    <= 5'd0;
            r_qsign  <= div_signed & (div_opr1[31] ^ div_opr2[31]);
            r_rsign  <= div_signed & div_opr1[31];
            div_busy <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
            r_state  <= (div_opr2 == 32'd0) ? S_ZERO : S_CALC;
`else
            r_state  <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_dvd <= {r_dvd[30:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state   <= S_DONE;
            div_ready <= 1'b1;
            div_quo   <= r_qsign ? (32'd0 - w_quo_next) : w_quo_next;
            div_rem   <= r_rsign ? (32'd0 - w_rem_next) : w_rem_next;
          end
        end
`ifdef DIV_ZERO_FAST_EN
        S_ZERO: begin
          // Same values the full algorithm yields for a zero divisor: |q| = all ones, |r| = |a|.
          r_state   <= S_DONE;
          div_ready <= 1'b1;
          div_quo   <= r_qsign ? 32'h0000_0001 : 32'hFFFF_FFFF;
          div_rem   <= r_rsign ? (32'd0 - r_dvd) : r_dvd;
        end
`endif
        S_DONE: begin
          r_state   <= S_IDLE;
          div_busy  <= 1'b0;
          div_ready <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          div_busy  <= 1'b0;
          div_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder vectors, latency, cancel, ignored start, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opr1;
  logic [31:0] div_opr2;
  logic        div_cancel;
  logic        div_busy;
  logic        div_ready;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [1:0]  div_dbg_state;

  int n_tests;
  int n_fail;
  int n_ready;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 33;
`endif

  div_unit dut (
    .clk           (clk),
    .rst           (rst),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .div_opr1      (div_opr1),
    .div_opr2      (div_opr2),
    .div_cancel    (div_cancel),
    .div_busy      (div_busy),
    .div_ready     (div_ready),
    .div_quo       (div_quo),
    .div_rem       (div_rem),
    .div_dbg_state (div_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (div_ready) n_ready++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives a start for one cycle; returns positioned in cycle 1 of the operation.
  task automatic drive_start(input logic sg, input logic [31:0] a, input logic [31:0] b);
    div_start  = 1'b1;
    div_signed = sg;
    div_opr1   = a;
    div_opr2   = b;
    next_cycle();
    div_start  = 1'b0;
  endtask

  // Waits for div_ready from cycle cyc_in; leaves time at the falling edge of the ready cycle.
  task automatic wait_ready(input int cyc_in, output int cyc_out);
    int  cyc;
    logic got;
    cyc = cyc_in;
    got = 1'b0;
    while (!got && cyc <= 100) begin
      @(negedge clk);
      if (div_ready) got = 1'b1;
      else begin
        next_cycle();
        cyc++;
      end
    end
    cyc_out = cyc;
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int lat);
    int cyc;
    drive_start(sg, a, b);
    wait_ready(1, cyc);
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_quo"}, div_quo, eq);
    check({tag, "_rem"}, div_rem, er);
    check({tag, "_busy_done"}, {31'd0, div_busy}, 32'd1);
    next_cycle();
    check({tag, "_busy_after"}, {31'd0, div_busy}, 32'd0);
    check({tag, "_ready_after"}, {31'd0, div_ready}, 32'd0);
  endtask

  initial begin
    int cyc;
    int r0;
    n_tests    = 0;
    n_fail     = 0;
    n_ready    = 0;
    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_opr1   = 32'd0;
    div_opr2   = 32'd0;
    div_cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, div_busy}, 32'd0);
    check("rst_ready", {31'd0, div_ready}, 32'd0);
    check("rst_quo", div_quo, 32'd0);
    check("rst_rem", div_rem, 32'd0);
    next_cycle();

    // result vectors (back-to-back, next start in cycle 34)
    run_op("divu_7_2",    1'b0, 32'd7,         32'd2,         32'h0000_0003, 32'h0000_0001, 33);
    run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33);
    run_op("divu_big",    1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 33);
    run_op("div_zero_s",  1'b1, 32'hFFFF_FFF0, 32'd0,         32'h0000_0001, 32'hFFFF_FFF0, ZERO_LAT);
    run_op("divu_zero",   1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'h0000_0005, ZERO_LAT);
    run_op("div_100_m7",  1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 33);

    // start and cancel together in IDLE: stays idle
    div_cancel = 1'b1;
    drive_start(1'b0, 32'd50, 32'd5);
    div_cancel = 1'b0;
    check("start_cancel_idle", {31'd0, div_busy}, 32'd0);

    // cancel in cycle 10: no ready, outputs keep prior result
    r0 = n_ready;
    drive_start(1'b0, 32'd100, 32'd7);
    for (int c = 1; c < 10; c++) next_cycle();
    div_cancel = 1'b1;
    next_cycle();
    div_cancel = 1'b0;
    @(negedge clk);
    check("cancel_no_ready", n_ready - r0, 32'd0);
    check("cancel_busy", {31'd0, div_busy}, 32'd0);
    check("cancel_quo_kept", div_quo, 32'hFFFF_FFF2);
    check("cancel_rem_kept", div_rem, 32'h0000_0002);
    next_cycle();
    run_op("after_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // start pulses in cycles 5..20 are ignored
    drive_start(1'b0, 32'd1000, 32'd7);
    for (int c = 1; c < 5; c++) next_cycle();
    div_signed = 1'b1;
    div_opr1   = 32'd50;
    div_opr2   = 32'd5;
    for (int c = 5; c <= 20; c++) begin
      div_start = 1'b1;
      next_cycle();
    end
    div_start = 1'b0;
    wait_ready(21, cyc);
    check("busy_start_lat", cyc, 33);
    check("busy_start_quo", div_quo, 32'd142);
    check("busy_start_rem", div_rem, 32'd6);
    next_cycle();

    // reset in cycle 15: everything clears, no ready pulse follows
    r0 = n_ready;
    drive_start(1'b0, 32'd1000, 32'd3);
    for (int c = 1; c < 15; c++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, div_busy}, 32'd0);
    check("midrst_ready", {31'd0, div_ready}, 32'd0);
    check("midrst_quo", div_quo, 32'd0);
    check("midrst_rem", div_rem, 32'd0);
    repeat (40) next_cycle();
    check("midrst_no_ready", n_ready - r0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
